fetch_unit: RTL and testbench

- Instruction-fetch initiator on the program ROM's read port.
- Drives the 16-bit ROM address, samples the ROM's combinational 8-bit data in the same cycle, and buffers bytes in a small prefetch FIFO tagged with their addresses.
- Presents bytes to the decoder over a valid/ready handshake.
- Accepts redirects (jumps/branches/interrupt vectors) that flush the buffer and restart fetch at a new address.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/fetch_unit.sv | 85 ++++++++
 tb/tb_fetch_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, defaults and types for the CPU front end.
//   ADDR_W / DATA_W       : program ROM address and data widths
//   RESET_VECTOR_DEFAULT  : default first fetch address after reset
//   fetch_entry_t         : one prefetched byte tagged with its ROM address
//   next_addr()           : sequential fetch address (wraps modulo 2^ADDR_W)
package cpu_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  localparam logic [ADDR_W-1:0] RESET_VECTOR_DEFAULT = 16'h0000;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } fetch_entry_t;

  // Plain increment; 16'hFFFF rolls over to 16'h0000 without any flag.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO of fetch_entry_t.
//   clk, rst    : clock, synchronous active-high reset
//   push, entry : write entry at the tail
//   pop         : drop the head entry
//   flush       : discard all contents (same effect as reset on pointers/count)
//   full, empty : occupancy flags, decoded from the registered count
//   count       : number of valid entries, 0..DEPTH
//   head        : entry at the read pointer (raw storage; meaningless when empty)
// The caller guarantees no push when full without a simultaneous pop, and no
// pop when empty. Push and pop in the same cycle while full is legal.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  fetch_entry_t       entry,
  input  logic               pop,
  input  logic               flush,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count,
  output fetch_entry_t       head
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed while count != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= entry;
    end
  end

  always_comb begin
    full  = (count == CNT_W'(DEPTH));
    empty = (count == '0);
    head  = mem[rd_ptr];
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch initiator on the program ROM read port.
//   clk, rst        : clock, synchronous active-high reset
//   rom_addr        : ROM address, straight from the fetch_addr register
//   rom_data        : combinational ROM data for rom_addr (same cycle)
//   fetch_en        : 1 = fetching permitted; 0 = no pushes, pops continue
//   redirect_valid  : one-cycle pulse, flush and restart at redirect_addr
//   redirect_addr   : new fetch address
//   out_valid       : prefetch buffer non-empty
//   out_ready       : decoder accepts the head byte
//   out_data        : head byte (0 while out_valid=0)
//   out_pc          : ROM address of the head byte (0 while out_valid=0)
// Redirect latency is two cycles: the redirect cycle loads fetch_addr, the
// next cycle pushes ROM[redirect_addr], and the one after presents it.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       DEPTH        = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_pc
);

  logic [ADDR_W-1:0]      fetch_addr;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  fetch_entry_t           wr_entry;
  fetch_entry_t           head;

  // out_valid/out_data/out_pc depend only on registered FIFO state, so the
  // decoder-side inputs never reach them combinationally.
  always_comb begin
    out_valid = (fifo_count != '0);
    out_data  = fifo_empty ? '0 : head.data;
    out_pc    = fifo_empty ? '0 : head.pc;
  end

  // A pop in a full cycle frees the slot the push is about to fill.
  always_comb begin
    pop      = out_valid & out_ready;
    push     = fetch_en & ~redirect_valid & (~fifo_full | pop);
    wr_entry = '{pc: fetch_addr, data: rom_data};
    rom_addr = fetch_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_addr <= RESET_VECTOR;
    end else if (redirect_valid) begin
      fetch_addr <= redirect_addr;
    end else if (push) begin
      fetch_addr <= next_addr(fetch_addr);
    end
  end

  // A pop coinciding with a redirect is still consumed by the decoder; the
  // flush then discards whatever remains.
  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .entry (wr_entry),
    .pop   (pop),
    .flush (redirect_valid),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        fetch_en;
  logic        redirect_valid;
  logic [15:0] redirect_addr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [15:0] out_pc;

  logic [7:0]  rom_mem [0:65535];
  logic [23:0] sb [$];

  int checks;
  int failures;

  fetch_unit #(
    .DEPTH        (4),
    .RESET_VECTOR (16'h0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_pc         (out_pc)
  );

  assign rom_data = rom_mem[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every accepted byte is compared with the oldest
  // expected {pc, data}; also bounds the occupancy.
  always @(negedge clk) begin
    logic [23:0] exp;
    if (!rst) begin
      checks++;
      if (dut.u_fifo.count > 3'd4) begin
        failures++;
        $display("FAIL count_bound: count=%0d max=4", dut.u_fifo.count);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (dut.u_fifo.count == 0) begin
          failures++;
          $display("FAIL pop_empty: pop with count=0");
        end else if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_underrun: got pc=%h data=%h, nothing expected", out_pc, out_data);
        end else begin
          exp = sb.pop_front();
          if ({out_pc, out_data} !== exp) begin
            failures++;
            $display("FAIL sb_pop: got pc=%h data=%h expected pc=%h data=%h",
                     out_pc, out_data, exp[23:8], exp[7:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_stream(input logic [15:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] p;
      p = start + 16'(i);
      sb.push_back({p, rom_mem[p]});
    end
  endtask

  task automatic apply_reset(input logic ready);
    rst = 1'b1;
    redirect_valid = 1'b0;
    fetch_en = 1'b1;
    out_ready = ready;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
    push_stream(16'h0000, 64);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fetch_en = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr = '0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || rom_addr !== 16'h0000 || out_data !== 8'h00 || out_pc !== 16'h0000) begin
      failures++;
      $display("FAIL reset_values: valid=%b addr=%h data=%h pc=%h expected 0/0000/00/0000",
               out_valid, rom_addr, out_data, out_pc);
    end
    rst = 1'b0;
    sb.delete();
    push_stream(16'h0000, 64);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL startup_idle: out_valid=%b expected 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 16'h0000 || out_data !== 8'h10) begin
      failures++;
      $display("FAIL startup_first: valid=%b pc=%h data=%h expected 1/0000/10",
               out_valid, out_pc, out_data);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 16'(i) || out_data !== 8'h10 + 8'(i)) begin
        failures++;
        $display("FAIL stream[%0d]: valid=%b pc=%h data=%h expected 1/%h/%h",
                 i, out_valid, out_pc, out_data, 16'(i), 8'h10 + 8'(i));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure();
    apply_reset(1'b0);
    repeat (10) tick();
    checks++;
    if (rom_addr !== 16'h0004 || dut.u_fifo.count !== 3'd4 || out_valid !== 1'b1 || out_pc !== 16'h0000) begin
      failures++;
      $display("FAIL full_hold: addr=%h count=%0d valid=%b pc=%h expected 0004/4/1/0000",
               rom_addr, dut.u_fifo.count, out_valid, out_pc);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 16'(i) || out_data !== 8'h10 + 8'(i)) begin
        failures++;
        $display("FAIL drain[%0d]: valid=%b pc=%h data=%h expected 1/%h/%h",
                 i, out_valid, out_pc, out_data, 16'(i), 8'h10 + 8'(i));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_redirect();
    apply_reset(1'b1);
    repeat (4) tick();
    redirect_valid = 1'b1;
    redirect_addr = 16'h0040;
    tick();
    redirect_valid = 1'b0;
    sb.delete();
    push_stream(16'h0040, 64);
    checks++;
    if (rom_addr !== 16'h0040 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL redirect_n1: addr=%h valid=%b expected 0040/0", rom_addr, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 16'h0040 || out_data !== 8'hA5) begin
      failures++;
      $display("FAIL redirect_n2: valid=%b pc=%h data=%h expected 1/0040/a5",
               out_valid, out_pc, out_data);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] p;
    logic [7:0]  d;
    rom_mem[16'h0000] = 8'h03;
    redirect_valid = 1'b1;
    redirect_addr = 16'hFFFE;
    out_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    sb.delete();
    push_stream(16'hFFFE, 64);
    tick();
    for (int i = 0; i < 3; i++) begin
      p = 16'hFFFE + 16'(i);
      d = 8'h01 + 8'(i);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== p || out_data !== d) begin
        failures++;
        $display("FAIL wrap[%0d]: valid=%b pc=%h data=%h expected 1/%h/%h",
                 i, out_valid, out_pc, out_data, p, d);
      end
      @(posedge clk);
      #1;
    end
    rom_mem[16'h0000] = 8'h10;
  endtask

  task automatic test_stall();
    redirect_valid = 1'b1;
    redirect_addr = 16'h0100;
    out_ready = 1'b0;
    fetch_en = 1'b1;
    tick();
    redirect_valid = 1'b0;
    sb.delete();
    push_stream(16'h0100, 64);
    tick();
    tick();
    fetch_en = 1'b0;
    checks++;
    if (rom_addr !== 16'h0102 || dut.u_fifo.count !== 3'd2) begin
      failures++;
      $display("FAIL stall_two: addr=%h count=%0d expected 0102/2", rom_addr, dut.u_fifo.count);
    end
    out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || rom_addr !== 16'h0102) begin
      failures++;
      $display("FAIL stall_drained: valid=%b addr=%h expected 0/0102", out_valid, rom_addr);
    end
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b0 || rom_addr !== 16'h0102) begin
      failures++;
      $display("FAIL stall_hold: valid=%b addr=%h expected 0/0102", out_valid, rom_addr);
    end
    fetch_en = 1'b1;
    out_ready = 1'b0;
    repeat (6) tick();
    checks++;
    if (dut.u_fifo.count !== 3'd4 || rom_addr !== 16'h0106 || out_pc !== 16'h0102) begin
      failures++;
      $display("FAIL refill_full: count=%0d addr=%h pc=%h expected 4/0106/0102",
               dut.u_fifo.count, rom_addr, out_pc);
    end
    redirect_valid = 1'b1;
    redirect_addr = 16'h0200;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 16'h0102) begin
      failures++;
      $display("FAIL redir_pop: valid=%b pc=%h expected 1/0102", out_valid, out_pc);
    end
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    sb.delete();
    push_stream(16'h0200, 64);
    checks++;
    if (out_valid !== 1'b0 || dut.u_fifo.count !== 3'd0 || rom_addr !== 16'h0200) begin
      failures++;
      $display("FAIL redir_flush: valid=%b count=%0d addr=%h expected 0/0/0200",
               out_valid, dut.u_fifo.count, rom_addr);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 16'h0200) begin
      failures++;
      $display("FAIL redir_first: valid=%b pc=%h expected 1/0200", out_valid, out_pc);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    fetch_en = 1'b1;
    repeat (6) tick();
    checks++;
    if (dut.u_fifo.count !== 3'd4) begin
      failures++;
      $display("FAIL mid_full: count=%0d expected 4", dut.u_fifo.count);
    end
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr = 16'h0123;
    tick();
    checks++;
    if (out_valid !== 1'b0 || rom_addr !== 16'h0000 || dut.u_fifo.count !== 3'd0) begin
      failures++;
      $display("FAIL mid_reset: valid=%b addr=%h count=%0d expected 0/0000/0",
               out_valid, rom_addr, dut.u_fifo.count);
    end
    rst = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    sb.delete();
    push_stream(16'h0000, 64);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 16'h0000 || out_data !== 8'h10) begin
      failures++;
      $display("FAIL mid_restart: valid=%b pc=%h data=%h expected 1/0000/10",
               out_valid, out_pc, out_data);
    end
    test_stream();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    fetch_en = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr = '0;
    for (int i = 0; i < 65536; i++) begin
      rom_mem[i] = 8'((i * 7) + 3);
    end
    for (int i = 0; i < 8; i++) begin
      rom_mem[i] = 8'h10 + 8'(i);
    end
    rom_mem[16'h0040] = 8'hA5;
    rom_mem[16'hFFFE] = 8'h01;
    rom_mem[16'hFFFF] = 8'h02;

    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_stall();
    test_reset_mid();

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
